// File: rtl/if_pc_gen.sv
// IF-stage program-counter generator. It owns the PC register, holds redirects that arrive during a stall, and
// optionally includes a return-address stack, which is enabled by defining IF_PC_RAS_EN.
module if_pc_gen #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Stall_IF,
    input  logic              Exc_req,
    input  logic [ADDR_W-1:0] Exc_vector,
    input  logic              Jump_control_ID,
    input  logic [ADDR_W-1:0] Jump_dst_ID,
    input  logic              PCSrc_ID,
    input  logic [ADDR_W-1:0] Branch_Dest_ID,
    input  logic              Ras_push_ID,
    input  logic [ADDR_W-1:0] Ras_link_ID,
    input  logic              Ras_pop_ID,
    output logic [ADDR_W-1:0] PC_IF,
    output logic [ADDR_W-1:0] PC_Plus_4_IF,
    output logic              Redirect_pending,
    output logic              Ras_empty
);

    // Redirect priority encoding; a larger value is a higher priority. Exceptions are never held.
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_POP  = 2'd2;
    localparam logic [1:0] PRI_JMP  = 2'd3;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_q, pend_d;
    logic [1:0]        pend_pri_q, pend_pri_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [1:0]        new_pri;
    logic [ADDR_W-1:0] new_addr;
    logic              ras_hit;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

`ifdef IF_PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  tp_q;
    logic [PTR_W-1:0]  tp_inc;
    logic [CNT_W-1:0]  cnt_q;

    assign tp_inc    = tp_q + 1'b1;
    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_mem_q[tp_q];
    assign ras_hit   = Ras_pop_ID && !ras_empty;

    // Push-and-pop in the same cycle replaces the top in place. A push to a full stack wraps and overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (Ras_push_ID && ras_hit) begin
            ras_mem_q[tp_q] <= Ras_link_ID;
        end else if (Ras_push_ID) begin
            ras_mem_q[tp_inc] <= Ras_link_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tp_q  <= '0;
            cnt_q <= '0;
        end else if (Exc_req) begin
            cnt_q <= '0;
        end else if (Ras_push_ID && !ras_hit) begin
            tp_q <= tp_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (ras_hit && !Ras_push_ID) begin
            tp_q  <= tp_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{Ras_push_ID, Ras_link_ID, Ras_pop_ID};
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign ras_hit    = 1'b0;
`endif

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        new_pri  = PRI_NONE;
        new_addr = pc_plus4;
        if (Jump_control_ID) begin
            new_pri  = PRI_JMP;
            new_addr = Jump_dst_ID;
        end else if (ras_hit) begin
            new_pri  = PRI_POP;
            new_addr = ras_top;
        end else if (PCSrc_ID) begin
            new_pri  = PRI_BR;
            new_addr = Branch_Dest_ID;
        end
    end

    // A held redirect belongs to an older instruction, so it beats whatever arrives on the release cycle.
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_pri_d  = pend_pri_q;
        pend_addr_d = pend_addr_q;
        if (Exc_req) begin
            pc_d       = Exc_vector;
            pend_d     = 1'b0;
            pend_pri_d = PRI_NONE;
        end else if (Stall_IF) begin
            if ((new_pri != PRI_NONE) && (!pend_q || (new_pri > pend_pri_q))) begin
                pend_d      = 1'b1;
                pend_pri_d  = new_pri;
                pend_addr_d = new_addr;
            end
        end else if (pend_q) begin
            pc_d       = pend_addr_q;
            pend_d     = 1'b0;
            pend_pri_d = PRI_NONE;
        end else begin
            pc_d = new_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pri_q  <= PRI_NONE;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_pri_q  <= pend_pri_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign PC_IF            = pc_q;
    assign PC_Plus_4_IF     = pc_plus4;
    assign Redirect_pending = pend_q;
    assign Ras_empty        = ras_empty;

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Parametrised program-counter generator for the IF stage of the MIPS32 pipeline. It owns the PC register and selects the next fetch address from exception, jump, return-address-stack, branch and sequential sources. Redirects that arrive while fetch is stalled are held and applied on release. It replaces the purely combinational next-PC selection and feeds the instruction memory address and IF/ID PC+4.

## Interface
Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded by reset, ADDR_W bits.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2); used only with IF_PC_RAS_EN.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
- Stall_IF  in  1  hold PC this cycle.
- Exc_req  in  1  exception redirect request.
- Exc_vector  in  ADDR_W  exception handler address.
- Jump_control_ID  in  1  jump redirect request.
- Jump_dst_ID  in  ADDR_W  jump target.
- PCSrc_ID  in  1  taken-branch redirect request.
- Branch_Dest_ID  in  ADDR_W  branch target.
- Ras_push_ID  in  1  push link address (JAL/JALR).
- Ras_link_ID  in  ADDR_W  address to push.
- Ras_pop_ID  in  1  return via stack top (JR $ra).
- PC_IF  out  ADDR_W  current fetch address.
- PC_Plus_4_IF  out  ADDR_W  PC_IF + 4, modulo 2^ADDR_W.
- Redirect_pending  out  1  held redirect waiting for stall release.
- Ras_empty  out  1  stack count is 0 (constant 1 without IF_PC_RAS_EN).

## Operation
- Reset (reset_n=0 at edge): PC_IF←RESET_PC, pending cleared, RAS count←0. Outputs after reset: PC_IF=RESET_PC, PC_Plus_4_IF=RESET_PC+4, Redirect_pending=0, Ras_empty=1.
- Redirect priority, highest first: Exc_req > Jump_control_ID > RAS pop (Ras_pop_ID and not empty) > PCSrc_ID > sequential PC+4.
- Exc_req is never stalled. It loads Exc_vector into PC_IF, clears pending and clears the RAS count.
- Stall_IF=1, no exception: PC_IF holds. A new redirect is latched into pending if none is held, or if its priority is strictly higher than the held one. Otherwise it is dropped.
- Stall_IF=0, pending held: PC_IF←pending address (the older instruction wins over new jump/branch/pop that cycle) and pending clears.
- Stall_IF=0, no pending: PC_IF←highest-priority source.
- RAS, circular buffer:
  - Push writes Ras_link_ID at top, count+1 saturating at RAS_DEPTH. A push when full overwrites the oldest entry.
  - Pop yields the top, count−1.
  - Pop when empty produces no redirect; selection falls to the next source.
  - Push and pop in the same cycle: the pop target is the old top, the push then replaces the top, and count is unchanged.
  - Stack ops execute regardless of Stall_IF. A pop target that arrives during a stall goes to pending.
- Arithmetic: all adds wrap modulo 2^ADDR_W. Targets are used unmodified (no alignment check).

## Timing
- 1-cycle latency: a redirect sampled at edge N appears on PC_IF after edge N.
- PC_Plus_4_IF is combinational from PC_IF.
- Redirect_pending is registered and asserts the cycle after capture.
- A reset asserted mid-stall discards pending and stack state in the same edge.
- No combinational path from any input to PC_IF.

## Configuration
- IF_PC_RAS_EN defined: RAS implemented as above with RAS_DEPTH entries.
- IF_PC_RAS_EN undefined: no stack storage is built. Ras_push_ID, Ras_link_ID and Ras_pop_ID are ignored, Ras_empty=1, and priority is Exc > Jump > Branch > PC+4.

## Test plan
- Reset with RESET_PC=0x00400000, then 3 free cycles → PC_IF = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- Jump_control_ID=1 with Jump_dst_ID=0x100 and PCSrc_ID=1 with Branch_Dest_ID=0x200 in the same cycle → PC_IF=0x100 the next cycle.
- Stall_IF=1 and PCSrc_ID=1 (0x200), then Jump_control_ID=1 (0x300) while still stalled, then release → Redirect_pending=1, PC_IF holds, and PC_IF=0x300 on the release edge.
- Exc_req=1 (Exc_vector=0x80000180) during stall with pending held → PC_IF=0x80000180 the next cycle, Redirect_pending=0, Ras_empty=1.
- RAS_EN, RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50, then pop ×5 → targets 0x50, 0x40, 0x30, 0x20. The fifth pop falls through to PC+4 with Ras_empty=1.
- PC_IF=0xFFFFFFFC free-running → PC_Plus_4_IF=0, and the next PC_IF=0x00000000.
